// File: rtl/spio_spinnaker_link_sync_tx_fifo_if.sv
// Flit handshake between the packet serializer and the SpiNNaker link transmit FIFO.
// The serializer is the master: it drives the 2-of-7 flit and valid, and receives ready.
interface spio_spinnaker_link_sync_tx_fifo_if;
   logic [6:0] flt_data_2of7;
   logic       flt_vld;
   logic       flt_rdy;

   modport master (
      output flt_data_2of7,
      output flt_vld,
      input  flt_rdy
   );

   modport slave (
      input  flt_data_2of7,
      input  flt_vld,
      output flt_rdy
   );
endinterface

// File: rtl/spio_spinnaker_link_sync_tx_fifo.sv
// Clocked transmit FIFO for the SpiNNaker 2-of-7 link: buffers NRZ flits and drives one
// flit per (synchronised) SL_ACK_IN transition, with flush, occupancy and ack timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | nothing in flight; launch mem[rd] as soon as the queue is non-empty
// WAIT_ACK | a flit is on the wires; waiting for the ack transition
module spio_spinnaker_link_sync_tx_fifo #(
   parameter int DEPTH          = 8,
   parameter int AW             = $clog2(DEPTH),
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                 CLK_IN,
   input  logic                                 RESET_N_IN,
   spio_spinnaker_link_sync_tx_fifo_if.slave    flt,
   input  logic                                 flush_in,
   output logic [AW:0]                          fifo_level,
   output logic                                 ack_timeout,
   output logic [6:0]                           SL_DATA_2OF7_OUT,
   input  logic                                 SL_ACK_IN
);

   typedef enum logic {
      IDLE,
      WAIT_ACK
   } state_t;

   localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit            TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);

   logic [6:0]             mem [DEPTH];
   logic [AW:0]            wr;
   logic [AW:0]            rd;
   logic [AW:0]            wr_nx;
   logic [AW:0]            rd_nx;
   logic [AW:0]            level_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic                   s_ack;
   logic                   old_ack;
   logic                   acked;
   logic                   wr_en;
   logic                   rd_en;
   logic [TW-1:0]          tmr;
   state_t                 state;

   assign s_ack = sync[SYNC_STAGES-1];
   assign acked = s_ack ^ old_ack;
   assign wr_en = flt.flt_vld & flt.flt_rdy & ~flush_in;
   assign rd_en = (fifo_level != '0) & ((state == IDLE) | ((state == WAIT_ACK) & acked));

   // Flush snaps rd onto the current wr; a write in the flush cycle is already gated off.
   always_comb begin
      wr_nx    = wr + {{AW{1'b0}}, wr_en};
      rd_nx    = flush_in ? wr : (rd + {{AW{1'b0}}, rd_en});
      level_nx = wr_nx - rd_nx;
   end

   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         wr          <= '0;
         rd          <= '0;
         fifo_level  <= '0;
         flt.flt_rdy <= 1'b0;
         sync        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem[wr[AW-1:0]] <= flt.flt_data_2of7;
         end
         wr          <= wr_nx;
         rd          <= rd_nx;
         fifo_level  <= level_nx;
         flt.flt_rdy <= (level_nx < FULL) & ~flush_in;
         sync        <= {sync[SYNC_STAGES-2:0], SL_ACK_IN};
      end
   end

   // Timeout is a down-counter loaded on every send; it never resends or abandons a flit.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         state            <= IDLE;
         SL_DATA_2OF7_OUT <= '0;
         old_ack          <= 1'b0;
         tmr              <= '0;
         ack_timeout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_en) begin
                  SL_DATA_2OF7_OUT <= mem[rd[AW-1:0]];
                  old_ack          <= s_ack;
                  tmr              <= T_LOAD;
                  state            <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (TO_EN && (tmr == '0)) begin
                  ack_timeout <= 1'b1;
               end
               if (acked) begin
                  if (rd_en) begin
                     SL_DATA_2OF7_OUT <= mem[rd[AW-1:0]];
                     old_ack          <= s_ack;
                     tmr              <= T_LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end else if (tmr != '0) begin
                  tmr <= tmr - TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spio_spinnaker_link_sync_tx_fifo.sv
// Scoreboard bench for the SpiNNaker link transmit FIFO: accepted flits are queued as
// expectations and a monitor compares every change of the link wires against them.
module tb_spio_spinnaker_link_sync_tx_fifo;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          flush   = 1'b0;
   logic          ack     = 1'b0;
   logic          timeout;
   logic [AW:0]   level;
   logic [6:0]    sl;

   spio_spinnaker_link_sync_tx_fifo_if flt_if ();

   spio_spinnaker_link_sync_tx_fifo #(
      .DEPTH          (DEPTH),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLK_IN           (clk),
      .RESET_N_IN       (rst_n),
      .flt              (flt_if),
      .flush_in         (flush),
      .fifo_level       (level),
      .ack_timeout      (timeout),
      .SL_DATA_2OF7_OUT (sl),
      .SL_ACK_IN        (ack)
   );

   always #5 clk = ~clk;

   int         errors   = 0;
   int         checks   = 0;
   int         n_out    = 0;
   int         kick     = 0;
   bit         auto_ack = 1'b0;
   logic [6:0] exp_q [$];

   function automatic void chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endfunction

   // Next NRZ 2-of-7 wire state: toggle two distinct wires, so it always differs from p.
   function automatic logic [6:0] nxt(input logic [6:0] p, input int i);
      logic [6:0] one;
      one = 7'd1;
      return p ^ ((one << (i % 7)) | (one << ((i + 3) % 7)));
   endfunction

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [6:0] v);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b1;
      @(posedge clk);
      #1;
      flt_if.flt_data_2of7 = v;
      flt_if.flt_vld       = 1'b1;
      forever begin
         @(negedge clk);
         if (flt_if.flt_rdy) break;
         n++;
         if (n > 300) begin
            ok = 1'b0;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         exp_q.push_back(v);
      end else begin
         chk("send_ready_timeout", 0, 1);
      end
      #1;
      flt_if.flt_vld = 1'b0;
   endtask

   task automatic wait_out(input string name, input int target, input int max, output int k);
      k = 0;
      while (n_out < target && k < max) begin
         look();
         k++;
      end
      chk(name, n_out, target);
   endtask

   // Monitor: every change of the link wires must be the oldest outstanding flit.
   initial begin
      logic [6:0] prev;
      logic [6:0] e;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = sl;
         end else if (sl != prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_flit", int'(sl), -1);
            end else begin
               e = exp_q.pop_front();
               chk("flit_order", int'(sl), int'(e));
            end
            n_out++;
            prev = sl;
         end
      end
   end

   // Link partner: toggles ack on request, or 4 cycles after each data change in auto mode.
   initial begin
      logic [6:0] aprev;
      int         pend;
      int         kdone;
      aprev = '0;
      pend  = -1;
      kdone = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ack   = 1'b0;
            aprev = sl;
            pend  = -1;
            kdone = kick;
         end else begin
            if (sl != aprev) begin
               aprev = sl;
               if (auto_ack) pend = 4;
            end
            if (kick != kdone) begin
               kdone = kick;
               ack   = ~ack;
            end else if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  ack  = ~ack;
                  pend = -1;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [6:0] v;
      logic [6:0] inflight;
      int         base_n;
      int         k;

      flt_if.flt_vld       = 1'b0;
      flt_if.flt_data_2of7 = '0;

      // Reset state
      #3;
      chk("rst_data", int'(sl), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_rdy", int'(flt_if.flt_rdy), 0);
      chk("rst_timeout", int'(timeout), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      look();
      chk("rdy_before_first_edge", int'(flt_if.flt_rdy), 0);
      look();
      chk("rdy_after_first_edge", int'(flt_if.flt_rdy), 1);

      // Single flit latency
      send(7'h03);
      look();
      chk("t1_data_not_yet", int'(sl), 0);
      look();
      chk("t1_data", int'(sl), 'h03);
      chk("t1_level", int'(level), 0);
      chk("t1_rdy", int'(flt_if.flt_rdy), 1);
      kick++;
      repeat (6) look();
      chk("t1_no_timeout", int'(timeout), 0);

      // Ack timeout with late ack
      send(7'h05);
      repeat (9) look();
      chk("t4_timeout_early", int'(timeout), 0);
      repeat (9) look();
      chk("t4_timeout_set", int'(timeout), 1);
      send(7'h0c);
      look();
      kick++;
      wait_out("t4_resume", 3, 8, k);
      chk("t4_timeout_sticky", int'(timeout), 1);
      kick++;
      repeat (6) look();

      // Reset while waiting for an ack
      send(7'h30);
      wait_out("t6_first", 4, 4, k);
      send(7'h33);
      send(7'h66);
      look();
      chk("t6_level_before", int'(level), 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_rst_data", int'(sl), 0);
      chk("t6_rst_level", int'(level), 0);
      chk("t6_rst_rdy", int'(flt_if.flt_rdy), 0);
      chk("t6_rst_timeout", int'(timeout), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      look();
      chk("t6_rdy_hold", int'(flt_if.flt_rdy), 0);
      look();
      chk("t6_rdy_back", int'(flt_if.flt_rdy), 1);
      send(7'h41);
      wait_out("t6_restart", 5, 4, k);
      kick++;
      repeat (6) look();

      // Fill: one in flight plus DEPTH queued, then release with one ack
      v        = 7'h41;
      base_n   = n_out;
      inflight = nxt(v, 0);
      for (int i = 0; i < DEPTH + 1; i++) begin
         v = nxt(v, i);
         send(v);
      end
      look();
      chk("t2_level_full", int'(level), DEPTH);
      chk("t2_rdy_full", int'(flt_if.flt_rdy), 0);
      chk("t2_inflight", int'(sl), int'(inflight));
      kick++;
      wait_out("t2_next_out", base_n + 2, 6, k);
      chk("t2_ack_latency_ok", int'(k <= 4), 1);
      chk("t2_rdy_after_ack", int'(flt_if.flt_rdy), 1);
      chk("t2_level_after_ack", int'(level), DEPTH - 1);
      auto_ack = 1'b1;
      kick++;
      wait_out("t2_drain", base_n + DEPTH + 1, 400, k);
      repeat (8) look();
      chk("t2_queue_empty", exp_q.size(), 0);

      // 64 flits with auto ack, covering pointer wrap
      base_n = n_out;
      for (int i = 0; i < 64; i++) begin
         v = nxt(v, i + 2);
         send(v);
      end
      wait_out("t3_all_out", base_n + 64, 800, k);
      repeat (8) look();
      chk("t3_queue_empty", exp_q.size(), 0);
      chk("t3_level", int'(level), 0);

      // Flush with a simultaneous write
      auto_ack = 1'b0;
      repeat (8) look();
      base_n   = n_out;
      inflight = nxt(v, 5);
      v        = inflight;
      send(v);
      for (int i = 0; i < 5; i++) begin
         v = nxt(v, i + 1);
         send(v);
      end
      look();
      chk("t5_level_queued", int'(level), 5);
      chk("t5_inflight", int'(sl), int'(inflight));
      @(posedge clk);
      #1;
      flush                = 1'b1;
      flt_if.flt_vld       = 1'b1;
      flt_if.flt_data_2of7 = nxt(v, 6);
      exp_q.delete();
      @(posedge clk);
      #1;
      flush          = 1'b0;
      flt_if.flt_vld = 1'b0;
      look();
      chk("t5_level_flushed", int'(level), 0);
      chk("t5_rdy_flush", int'(flt_if.flt_rdy), 0);
      look();
      chk("t5_rdy_after", int'(flt_if.flt_rdy), 1);
      repeat (3) look();
      chk("t5_output_held", int'(sl), int'(inflight));
      chk("t5_no_send", n_out, base_n + 1);
      kick++;
      repeat (8) look();
      chk("t5_idle_no_send", n_out, base_n + 1);
      chk("t5_idle_level", int'(level), 0);
      send(nxt(inflight, 3));
      wait_out("t5_after_flush_send", base_n + 2, 6, k);
      kick++;
      repeat (6) look();

      chk("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
